// File: rtl/zet_int_arbiter.sv
// ---------------------------------------------------------------------------
// zet_int_arbiter
//
// Interrupt controller placed in front of the Zet instruction decoder.
// It collects eight IRQ lines and one NMI line, and applies the mask
// register. It uses fully nested priority, where bit 0 is the highest
// priority. It drives the decoder's intr/nmir request lines. When the
// decoder acknowledges a maskable request, the controller answers with
// an 8-bit vector. The serviced line is then marked in-service until
// software issues an EOI.
//
// Parameters
//   VEC_BASE   vector returned for irq[0]; irq[i] returns VEC_BASE+i (mod 256)
//   LEVEL      0 = rising-edge triggered irq lines, 1 = level triggered
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active high
//   irq        external interrupt requests, bit 0 highest priority
//   nmi_in     non-maskable interrupt line, rising-edge triggered
//   intr       maskable interrupt request to the decoder
//   inta       one-cycle acknowledge pulse from the decoder
//   nmir       NMI request to the decoder
//   nmia       one-cycle NMI acknowledge pulse from the decoder
//   vector     interrupt vector, valid while vec_valid is high
//   vec_valid  one-cycle pulse qualifying vector
//   eoi        one-cycle pulse, clears the highest-priority in-service bit
//   mask_we    write strobe for the mask register
//   mask_din   new mask value, 1 = masked
//   mask       current mask register
// ---------------------------------------------------------------------------
module zet_int_arbiter #(
    parameter logic [7:0] VEC_BASE = 8'h08,
    parameter bit         LEVEL    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq,
    input  logic       nmi_in,
    output logic       intr,
    input  logic       inta,
    output logic       nmir,
    input  logic       nmia,
    output logic [7:0] vector,
    output logic       vec_valid,
    input  logic       eoi,
    input  logic       mask_we,
    input  logic [7:0] mask_din,
    output logic [7:0] mask
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_irr;
    logic [7:0] r_isr;
    logic [7:0] r_imr;
    logic [7:0] r_irq_prev;
    logic       r_nmi_prev;
    logic       r_intr;
    logic       r_nmir;
    logic [7:0] r_vector;
    logic       r_vec_valid;

    logic [7:0] w_pend;
    logic [7:0] w_prio_ok;
    logic [7:0] w_elig;
    logic       w_any;
    logic [2:0] w_win;
    logic [7:0] w_win_onehot;

    logic       w_accept;
    logic       w_take;
    logic       w_intr_next;
    logic       w_vec_valid_next;
    logic [7:0] w_vector_next;

    logic [7:0] w_irq_edge;
    logic [7:0] w_irr_next;
    logic [7:0] w_isr_lsb;
    logic [7:0] w_isr_next;
    logic       w_nmi_edge;
    logic       w_nmir_next;

    // -----------------------------------------------------------------------
    // Priority resolution
    // -----------------------------------------------------------------------
    assign w_pend = r_irr & ~r_imr;

    // A request is allowed only if no in-service bit sits at its index or
    // above it in priority. That is the fully nested rule.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_prio
            assign w_prio_ok[gi] = ~|r_isr[gi:0];
        end
    endgenerate

    assign w_elig       = w_pend & w_prio_ok;
    assign w_any        = |w_elig;
    assign w_win_onehot = w_elig & (~w_elig + 8'd1);

    always_comb begin
        w_win = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = 3'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_next = S_REQ;
            S_REQ: begin
                if (inta) begin
                    w_state_next = S_ACK;
                end else if (!w_any) begin
                    w_state_next = S_IDLE;
                end
            end
            S_ACK:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic (next values of the registered handshake outputs)
    // -----------------------------------------------------------------------
    always_comb begin
        w_accept         = 1'b0;
        w_take           = 1'b0;
        w_intr_next      = 1'b0;
        w_vec_valid_next = 1'b0;
        w_vector_next    = r_vector;
        case (r_state)
            S_IDLE: w_intr_next = w_any;
            S_REQ: begin
                if (inta) begin
                    w_accept         = 1'b1;
                    w_take           = w_any;
                    w_vec_valid_next = 1'b1;
                    // An empty eligible set at acknowledge time is spurious:
                    // return the lowest-priority vector.
                    w_vector_next    = w_any ? (VEC_BASE + {5'd0, w_win})
                                             : (VEC_BASE + 8'd7);
                end else begin
                    w_intr_next = w_any;
                end
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Request / in-service / mask datapath
    // -----------------------------------------------------------------------
    assign w_irq_edge = irq & ~r_irq_prev;

    // A fresh edge must survive a same-cycle acknowledge clear. That is why
    // the edge is ORed in after the clear.
    always_comb begin
        w_irr_next = r_irr;
        if (LEVEL) begin
            w_irr_next = irq;
        end else begin
            w_irr_next = (r_irr & ~(w_take ? w_win_onehot : 8'h00)) | w_irq_edge;
        end
    end

    // EOI retires the lowest set isr bit of the old isr. The winner of a
    // same-cycle acknowledge was already chosen against that old isr.
    assign w_isr_lsb  = r_isr & (~r_isr + 8'd1);
    assign w_isr_next = (eoi ? (r_isr & ~w_isr_lsb) : r_isr)
                      | (w_take ? w_win_onehot : 8'h00);

    assign w_nmi_edge  = nmi_in & ~r_nmi_prev;
    assign w_nmir_next = w_nmi_edge | (r_nmir & ~nmia);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irr       <= 8'h00;
            r_isr       <= 8'h00;
            r_imr       <= 8'hFF;
            r_irq_prev  <= 8'h00;
            r_nmi_prev  <= 1'b0;
            r_intr      <= 1'b0;
            r_nmir      <= 1'b0;
            r_vector    <= 8'h00;
            r_vec_valid <= 1'b0;
        end else begin
            r_irr       <= w_irr_next;
            r_isr       <= w_isr_next;
            if (mask_we) begin
                r_imr <= mask_din;
            end
            r_irq_prev  <= irq;
            r_nmi_prev  <= nmi_in;
            r_intr      <= w_intr_next;
            r_nmir      <= w_nmir_next;
            r_vector    <= w_vector_next;
            r_vec_valid <= w_vec_valid_next;
        end
    end

    assign intr      = r_intr;
    assign nmir      = r_nmir;
    assign vector    = r_vector;
    assign vec_valid = r_vec_valid;
    assign mask      = r_imr;

endmodule

// File: tb/tb_zet_int_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zet_int_arbiter
//
// Two instances are tested:
//   u_a : edge triggered, VEC_BASE = 8'h08
//   u_b : level triggered, VEC_BASE = 8'hFC
// Each expected vector is queued when inta is driven. A monitor pops the
// queue and compares whenever vec_valid is seen.
// ---------------------------------------------------------------------------
module tb_zet_int_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       a_rst, a_nmi_in, a_inta, a_nmia, a_eoi, a_mask_we;
    logic [7:0] a_irq, a_mask_din;
    logic       a_intr, a_nmir, a_vec_valid;
    logic [7:0] a_vector, a_mask;

    logic       b_rst, b_nmi_in, b_inta, b_nmia, b_eoi, b_mask_we;
    logic [7:0] b_irq, b_mask_din;
    logic       b_intr, b_nmir, b_vec_valid;
    logic [7:0] b_vector, b_mask;

    logic [7:0] a_exp_q[$];
    logic [7:0] b_exp_q[$];
    logic [7:0] a_e, b_e;

    zet_int_arbiter #(.VEC_BASE(8'h08), .LEVEL(1'b0)) u_a (
        .clk(clk), .rst(a_rst), .irq(a_irq), .nmi_in(a_nmi_in),
        .intr(a_intr), .inta(a_inta), .nmir(a_nmir), .nmia(a_nmia),
        .vector(a_vector), .vec_valid(a_vec_valid), .eoi(a_eoi),
        .mask_we(a_mask_we), .mask_din(a_mask_din), .mask(a_mask)
    );

    zet_int_arbiter #(.VEC_BASE(8'hFC), .LEVEL(1'b1)) u_b (
        .clk(clk), .rst(b_rst), .irq(b_irq), .nmi_in(b_nmi_in),
        .intr(b_intr), .inta(b_inta), .nmir(b_nmir), .nmia(b_nmia),
        .vector(b_vector), .vec_valid(b_vec_valid), .eoi(b_eoi),
        .mask_we(b_mask_we), .mask_din(b_mask_din), .mask(b_mask)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every vec_valid pulse must match the next queued vector.
    always @(negedge clk) begin
        if (a_vec_valid) begin
            if (a_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_vector_unexpected: got %02h, expected no vector", a_vector);
            end else begin
                a_e = a_exp_q.pop_front();
                check("a_vector", 32'(a_vector), 32'(a_e));
                $display("a: vector %02h (expected %02h)", a_vector, a_e);
            end
        end
        if (b_vec_valid) begin
            if (b_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_vector_unexpected: got %02h, expected no vector", b_vector);
            end else begin
                b_e = b_exp_q.pop_front();
                check("b_vector", 32'(b_vector), 32'(b_e));
                $display("b: vector %02h (expected %02h)", b_vector, b_e);
            end
        end
    end

    initial begin
        a_rst = 1'b1; a_irq = 8'h10; a_nmi_in = 1'b0; a_inta = 1'b0; a_nmia = 1'b0;
        a_eoi = 1'b0; a_mask_we = 1'b0; a_mask_din = 8'h00;
        b_rst = 1'b1; b_irq = 8'h00; b_nmi_in = 1'b0; b_inta = 1'b0; b_nmia = 1'b0;
        b_eoi = 1'b0; b_mask_we = 1'b0; b_mask_din = 8'h00;
        tick(2);

        // Reset state (irq[4] held high through reset)
        check("rst_intr", 32'(a_intr), 0);
        check("rst_nmir", 32'(a_nmir), 0);
        check("rst_vec_valid", 32'(a_vec_valid), 0);
        check("rst_vector", 32'(a_vector), 0);
        check("rst_mask", 32'(a_mask), 32'h FF);
        check("rst_irr", 32'(u_a.r_irr), 0);
        check("rst_isr", 32'(u_a.r_isr), 0);

        // A line already high at reset release registers an edge
        a_rst = 1'b0; tick();
        check("first_edge_irr", 32'(u_a.r_irr), 32'h10);
        check("first_edge_masked_intr", 32'(a_intr), 0);
        a_mask_din = 8'h00; a_mask_we = 1'b1; tick(); a_mask_we = 1'b0;
        check("mask_written", 32'(a_mask), 32'h00);
        check("mask_delay_intr", 32'(a_intr), 0);
        tick();
        check("first_edge_intr", 32'(a_intr), 1);
        a_inta = 1'b1; a_exp_q.push_back(8'h0C); tick(); a_inta = 1'b0;
        check("irq4_isr", 32'(u_a.r_isr), 32'h10);
        a_irq = 8'h00; tick();
        a_eoi = 1'b1; tick(); a_eoi = 1'b0;
        check("irq4_eoi_isr", 32'(u_a.r_isr), 0);

        // irq[3] pulse: intr two cycles after the edge, vector 0B
        a_irq = 8'h08; tick(); a_irq = 8'h00;
        check("irq3_intr_lat1", 32'(a_intr), 0);
        tick();
        check("irq3_intr_lat2", 32'(a_intr), 1);
        a_inta = 1'b1; a_exp_q.push_back(8'h0B); tick(); a_inta = 1'b0;
        check("irq3_vec_valid", 32'(a_vec_valid), 1);
        check("irq3_intr_drop", 32'(a_intr), 0);
        check("irq3_isr", 32'(u_a.r_isr), 32'h08);
        tick();
        check("irq3_vec_valid_pulse", 32'(a_vec_valid), 0);

        // Nesting: irq[5] and irq[1] together with isr[3] set
        a_irq = 8'h22; tick(); a_irq = 8'h00;
        check("nest_irr", 32'(u_a.r_irr), 32'h22);
        tick();
        check("nest_intr", 32'(a_intr), 1);
        a_inta = 1'b1; a_exp_q.push_back(8'h09); tick(); a_inta = 1'b0;
        check("nest_isr", 32'(u_a.r_isr), 32'h0A);
        check("nest_irr_cleared", 32'(u_a.r_irr), 32'h20);
        tick(2);
        check("nest_irq5_blocked", 32'(a_intr), 0);
        a_eoi = 1'b1; tick(); a_eoi = 1'b0;
        check("eoi1_isr", 32'(u_a.r_isr), 32'h08);
        tick();
        check("eoi1_irq5_blocked", 32'(a_intr), 0);
        a_eoi = 1'b1; tick(); a_eoi = 1'b0;
        check("eoi2_isr", 32'(u_a.r_isr), 0);
        check("eoi2_intr_lat", 32'(a_intr), 0);
        tick();
        check("irq5_intr", 32'(a_intr), 1);
        a_inta = 1'b1; a_exp_q.push_back(8'h0D); tick(); a_inta = 1'b0;
        check("irq5_isr", 32'(u_a.r_isr), 32'h20);
        tick();
        a_eoi = 1'b1; tick(); a_eoi = 1'b0;
        check("irq5_eoi_isr", 32'(u_a.r_isr), 0);

        // Masked out after intr asserted; inta in that cycle is spurious
        a_irq = 8'h04; tick(); a_irq = 8'h00; tick();
        check("irq2_intr", 32'(a_intr), 1);
        a_mask_din = 8'h04; a_mask_we = 1'b1; tick(); a_mask_we = 1'b0;
        check("mask04", 32'(a_mask), 32'h04);
        check("mask04_intr_still", 32'(a_intr), 1);
        a_inta = 1'b1; a_exp_q.push_back(8'h0F); tick(); a_inta = 1'b0;
        check("spur_intr", 32'(a_intr), 0);
        check("spur_isr", 32'(u_a.r_isr), 0);
        check("spur_irr_kept", 32'(u_a.r_irr), 32'h04);
        tick();
        a_inta = 1'b1; tick(); a_inta = 1'b0;
        check("idle_inta_ignored", 32'(a_vec_valid), 0);
        tick();
        check("idle_inta_ignored2", 32'(a_vec_valid), 0);
        a_mask_din = 8'h00; a_mask_we = 1'b1; tick(); a_mask_we = 1'b0; tick();
        check("unmask_intr", 32'(a_intr), 1);
        a_inta = 1'b1; a_exp_q.push_back(8'h0A); tick(); a_inta = 1'b0;
        check("irq2_isr", 32'(u_a.r_isr), 32'h04);
        tick();

        // Simultaneous eoi and inta: eoi on old isr, then winner set
        a_irq = 8'h01; tick(); a_irq = 8'h00; tick();
        check("irq0_intr", 32'(a_intr), 1);
        a_inta = 1'b1; a_eoi = 1'b1; a_exp_q.push_back(8'h08); tick();
        a_inta = 1'b0; a_eoi = 1'b0;
        check("eoi_inta_isr", 32'(u_a.r_isr), 32'h01);
        tick();
        a_eoi = 1'b1; tick(); a_eoi = 1'b0;

        // NMI path independent of a pending intr
        a_irq = 8'h01; tick(); a_irq = 8'h00; tick();
        check("nmi_intr_pending", 32'(a_intr), 1);
        a_nmi_in = 1'b1; tick();
        check("nmi_set", 32'(a_nmir), 1);
        check("nmi_intr_indep", 32'(a_intr), 1);
        a_nmi_in = 1'b0; a_nmia = 1'b1; tick(); a_nmia = 1'b0;
        check("nmi_ack", 32'(a_nmir), 0);
        check("nmi_ack_intr", 32'(a_intr), 1);
        a_nmi_in = 1'b1; tick();
        check("nmi_set2", 32'(a_nmir), 1);
        a_nmi_in = 1'b0; tick();
        a_nmi_in = 1'b1; a_nmia = 1'b1; tick();
        check("nmi_edge_with_ack", 32'(a_nmir), 1);
        a_nmi_in = 1'b0; a_nmia = 1'b0; tick();
        check("nmi_hold", 32'(a_nmir), 1);
        a_nmia = 1'b1; tick(); a_nmia = 1'b0;
        check("nmi_ack2", 32'(a_nmir), 0);
        a_inta = 1'b1; a_exp_q.push_back(8'h08); tick(); a_inta = 1'b0;
        tick();

        // Reset with irr=06, isr=01, nmir=1
        a_irq = 8'h06; tick(); a_irq = 8'h00;
        a_nmi_in = 1'b1; tick(); a_nmi_in = 1'b0;
        check("pre_rst_irr", 32'(u_a.r_irr), 32'h06);
        check("pre_rst_isr", 32'(u_a.r_isr), 32'h01);
        check("pre_rst_nmir", 32'(a_nmir), 1);
        a_rst = 1'b1; tick();
        check("rst2_intr", 32'(a_intr), 0);
        check("rst2_nmir", 32'(a_nmir), 0);
        check("rst2_irr", 32'(u_a.r_irr), 0);
        check("rst2_isr", 32'(u_a.r_isr), 0);
        check("rst2_mask", 32'(a_mask), 32'h FF);
        check("rst2_vec_valid", 32'(a_vec_valid), 0);
        check("rst2_vector", 32'(a_vector), 0);
        a_rst = 1'b0;

        // Reset while in REQ
        a_mask_din = 8'h00; a_mask_we = 1'b1; tick(); a_mask_we = 1'b0;
        a_irq = 8'h02; tick(); a_irq = 8'h00; tick();
        check("req_before_rst", 32'(a_intr), 1);
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        check("rst3_intr", 32'(a_intr), 0);
        check("rst3_irr", 32'(u_a.r_irr), 0);
        check("rst3_mask", 32'(a_mask), 32'h FF);
        tick();
        check("rst3_intr_after", 32'(a_intr), 0);

        // Level mode, VEC_BASE=FC: irq[6] -> vector 02 (wraps)
        b_rst = 1'b0; tick();
        b_mask_din = 8'h00; b_mask_we = 1'b1; tick(); b_mask_we = 1'b0;
        b_irq = 8'h40; tick();
        check("lvl_irr", 32'(u_b.r_irr), 32'h40);
        tick();
        check("lvl_intr", 32'(b_intr), 1);
        b_inta = 1'b1; b_exp_q.push_back(8'h02); tick(); b_inta = 1'b0;
        check("lvl_isr", 32'(u_b.r_isr), 32'h40);
        check("lvl_irr_tracks", 32'(u_b.r_irr), 32'h40);
        check("lvl_vec_valid", 32'(b_vec_valid), 1);
        tick();
        check("lvl_nested_intr", 32'(b_intr), 0);
        b_eoi = 1'b1; tick(); b_eoi = 1'b0;
        check("lvl_eoi_isr", 32'(u_b.r_isr), 0);
        tick();
        check("lvl_reassert", 32'(b_intr), 1);
        b_irq = 8'h00; tick();
        check("lvl_drop_lat", 32'(b_intr), 1);
        tick();
        check("lvl_drop_intr", 32'(b_intr), 0);
        tick(2);
        check("lvl_no_new_req", 32'(b_intr), 0);
        check("lvl_irr_clear", 32'(u_b.r_irr), 0);

        tick(2);
        check("a_queue_drained", 32'(a_exp_q.size()), 0);
        check("b_queue_drained", 32'(b_exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
